// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential initiator for the ripple ALU. Accepts a decoded
// request, drives registered operands/ALUOp/CarryIn, holds them while the
// ripple settles, captures Result/CarryOut and returns result plus flags.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH         = 6,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_class,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_ovf,
    output logic             rsp_err
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_op;
    logic             r_alu_cin;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_carry;
    logic             r_rsp_zero;
    logic             r_rsp_neg;
    logic             r_rsp_ovf;
    logic             r_rsp_err;

    logic             w_legal;
    logic [3:0]       w_op;
    logic             w_cin;
    logic             w_arith;
    logic             w_sub;
    logic             w_ovf;

    // Decode request class/funct fields into ALUOp, CarryIn and legality.
    always_comb begin
        w_legal = 1'b1;
        w_op    = OP_ADD;
        w_cin   = 1'b0;
        case (req_class)
            2'b00: begin
                w_op  = OP_ADD;
                w_cin = 1'b0;
            end
            2'b01: begin
                w_op  = OP_SUB;
                w_cin = 1'b1;
            end
            2'b10: begin
                case (req_funct3)
                    3'b000: begin
                        w_op  = req_funct7b5 ? OP_SUB : OP_ADD;
                        w_cin = req_funct7b5;
                    end
                    3'b111: w_op = OP_AND;
                    3'b110: w_op = OP_OR;
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Flags derived from the held operands and the settled ALU outputs.
    always_comb begin
        w_arith = (r_alu_op[1:0] == 2'b10);
        w_sub   = r_alu_op[2];
        w_ovf   = w_arith
                  && ((r_alu_a[MSB] ^ r_alu_b[MSB]) == w_sub)
                  && (alu_result[MSB] != r_alu_a[MSB]);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = w_legal ? SETTLE : RESP;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand/opcode registers, settle counter and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_alu_cin    <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_neg    <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_legal) begin
                            r_alu_a   <= req_a;
                            r_alu_b   <= req_b;
                            r_alu_op  <= w_op;
                            r_alu_cin <= w_cin;
                            r_cnt     <= CNT_INIT;
                        end else begin
                            r_rsp_result <= '0;
                            r_rsp_carry  <= 1'b0;
                            r_rsp_zero   <= 1'b0;
                            r_rsp_neg    <= 1'b0;
                            r_rsp_ovf    <= 1'b0;
                            r_rsp_err    <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_rsp_result <= alu_result;
                        r_rsp_carry  <= w_arith & alu_cout;
                        r_rsp_zero   <= (alu_result == '0);
                        r_rsp_neg    <= alu_result[MSB];
                        r_rsp_ovf    <= w_ovf;
                        r_rsp_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign alu_cin    = r_alu_cin;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_neg    = r_rsp_neg;
    assign rsp_ovf    = r_rsp_ovf;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural ripple-ALU environment, a
// scoreboard queue filled by the driver and drained by a monitor.
module tb_alu_issue_ctrl;

    localparam int unsigned W = 6;
    localparam int unsigned S = 2;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_class;
    logic [2:0]   req_funct3;
    logic         req_funct7b5;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_op;
    logic         alu_cin;
    logic [W-1:0] alu_result;
    logic         alu_cout;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         rsp_neg;
    logic         rsp_ovf;
    logic         rsp_err;

    alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         neg;
        logic         ovf;
        logic         err;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic         cin;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    bit           seen    = 0;
    int           rdy_mode = 2;   // 0 random, 1 held low, 2 held high
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    logic [3:0]   last_op = '0;
    logic         last_cin = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bit-slice ripple ALU: optional invert of each input, then and/or/add.
    logic [W-1:0] env_av;
    logic [W-1:0] env_bv;
    logic [W:0]   env_sum;
    always_comb begin
        env_av   = alu_op[3] ? ~alu_a : alu_a;
        env_bv   = alu_op[2] ? ~alu_b : alu_b;
        env_sum  = {1'b0, env_av} + {1'b0, env_bv} + {{W{1'b0}}, alu_cin};
        alu_cout = env_sum[W];
        case (alu_op[1:0])
            2'b00:   alu_result = env_av & env_bv;
            2'b01:   alu_result = env_av | env_bv;
            2'b10:   alu_result = env_sum[W-1:0];
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Ready generator.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = ($urandom_range(0, 3) != 0);
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compare the presented response against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rsp_valid) begin
                    check("req_ready_busy", req_ready, 0);
                    if (sb.size() == 0) begin
                        fail_now("rsp_unexpected");
                    end else begin
                        e = sb[0];
                        if (!seen) begin
                            check("latency", cyc - e.acc, e.lat);
                            seen = 1;
                        end
                        check("rsp_result", rsp_result, e.res);
                        check("rsp_carry",  rsp_carry,  e.carry);
                        check("rsp_zero",   rsp_zero,   e.zero);
                        check("rsp_neg",    rsp_neg,    e.neg);
                        check("rsp_ovf",    rsp_ovf,    e.ovf);
                        check("rsp_err",    rsp_err,    e.err);
                        check("alu_a",      alu_a,      e.a);
                        check("alu_b",      alu_b,      e.b);
                        check("alu_op",     alu_op,     e.op);
                        check("alu_cin",    alu_cin,    e.cin);
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            seen = 0;
                        end
                    end
                end else if (sb.size() != 0 && !seen && cyc > sb[0].acc + sb[0].lat) begin
                    fail_now("rsp_valid_late");
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Reference model plus driver: compute the expected response, issue, push.
    task automatic issue(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   kind;     // 0 add, 1 sub, 2 and, 3 or, 4 illegal
        int   ia, ib, sa, sbv, sres, full;
        int   k;
        ia  = int'(a);
        ib  = int'(b);
        sa  = (ia >= 32) ? ia - 64 : ia;
        sbv = (ib >= 32) ? ib - 64 : ib;
        if (cls == 2'd0)      kind = 0;
        else if (cls == 2'd1) kind = 1;
        else if (cls == 2'd2) kind = (f3 == 3'd0) ? (f7 ? 1 : 0) :
                                     (f3 == 3'd7) ? 2 : (f3 == 3'd6) ? 3 : 4;
        else                  kind = 4;
        e.carry = 0; e.ovf = 0; e.err = 0; e.res = '0;
        e.a = a; e.b = b; e.cin = 0; e.op = 4'b0000;
        case (kind)
            0: begin
                full = ia + ib; e.res = W'(full % 64); e.carry = (full >= 64);
                sres = sa + sbv; e.ovf = (sres > 31) || (sres < -32);
                e.op = 4'b0010;
            end
            1: begin
                full = ia - ib; e.res = W'((full + 64) % 64); e.carry = (ia >= ib);
                sres = sa - sbv; e.ovf = (sres > 31) || (sres < -32);
                e.op = 4'b0110; e.cin = 1;
            end
            2: begin e.res = a & b; e.op = 4'b0000; end
            3: begin e.res = a | b; e.op = 4'b0001; end
            default: begin
                e.err = 1; e.a = last_a; e.b = last_b; e.op = last_op; e.cin = last_cin;
            end
        endcase
        e.zero = (kind != 4) && (e.res == '0);
        e.neg  = (kind != 4) && e.res[W-1];
        e.lat  = (kind == 4) ? 0 : S;
        if (kind != 4) begin
            last_a = e.a; last_b = e.b; last_op = e.op; last_cin = e.cin;
        end
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (k == 200) begin
            fail_now("req_ready_timeout");
            return;
        end
        req_valid    = 1'b1;
        req_class    = cls;
        req_funct3   = f3;
        req_funct7b5 = f7;
        req_a        = a;
        req_b        = b;
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        req_valid    = 1'b0;
        req_class    = 2'($urandom);
        req_funct3   = 3'($urandom);
        req_funct7b5 = 1'($urandom);
        req_a        = W'($urandom);
        req_b        = W'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
            seen = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  req_ready,  1);
        check({tag, "_rsp_valid"},  rsp_valid,  0);
        check({tag, "_alu_a"},      alu_a,      0);
        check({tag, "_alu_b"},      alu_b,      0);
        check({tag, "_alu_op"},     alu_op,     0);
        check({tag, "_alu_cin"},    alu_cin,    0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_flags"},  {rsp_carry, rsp_zero, rsp_neg, rsp_ovf, rsp_err}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] cls;
        logic [2:0] f3;
        int         r;
        int         k;
        reset = 1'b1; req_valid = 1'b0; req_class = '0; req_funct3 = '0;
        req_funct7b5 = 1'b0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        rdy_mode = 2;
        issue(2'b10, 3'b000, 1'b0, 6'd20, 6'd25);
        issue(2'b01, 3'b000, 1'b0, 6'd5, 6'd9);
        issue(2'b01, 3'b000, 1'b0, 6'd9, 6'd9);
        issue(2'b10, 3'b111, 1'b0, 6'h2A, 6'h0F);
        issue(2'b10, 3'b010, 1'b0, 6'd13, 6'd7);
        issue(2'b10, 3'b110, 1'b0, 6'h21, 6'h12);
        issue(2'b10, 3'b000, 1'b1, 6'd0, 6'd1);
        issue(2'b11, 3'b000, 1'b0, 6'd1, 6'd1);
        issue(2'b00, 3'b000, 1'b0, 6'd63, 6'd1);
        issue(2'b01, 3'b000, 1'b0, 6'd32, 6'd1);
        drain();

        // Stall with ready low, then abort a second request with reset.
        rdy_mode = 1;
        issue(2'b10, 3'b000, 1'b0, 6'd20, 6'd25);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (k == 50) fail_now("stall_rsp_timeout");
        repeat (5) @(negedge clk);
        rdy_mode = 2;
        drain();
        @(negedge clk);
        check("rsp_hold_after_hs", rsp_result, 45);
        check("rsp_valid_after_hs", rsp_valid, 0);
        issue(2'b00, 3'b000, 1'b0, 6'd7, 6'd8);
        #2;
        reset = 1'b1;
        sb.delete();
        seen = 0;
        last_a = '0; last_b = '0; last_op = '0; last_cin = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("post_abort");

        // Randomized traffic.
        rdy_mode = 0;
        for (int n = 0; n < 200; n++) begin
            cls = 2'($urandom_range(0, 3));
            r   = $urandom_range(0, 3);
            f3  = (r == 0) ? 3'd0 : (r == 1) ? 3'd7 : (r == 2) ? 3'd6 : 3'($urandom_range(0, 7));
            issue(cls, f3, 1'($urandom), W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 2;
        drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
